// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, encodings and the IF/ID entry type for the pipelined MIPS core
package mips_pkg;

    localparam int          DEF_INSTR_W   = 32;
    localparam int          DEF_PC_W      = 32;
    localparam int          DEF_PC_INC    = 4;
    localparam int          DEF_CNT_W     = 16;
    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_PC_W-1:0]    pc_next;
    } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: CNT_W-wide event counter that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // advance only while below the ceiling
    always_comb begin
        cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // counter state, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with 2-entry skid buffer, flush and perf counters
module if_id_skid_reg
    import mips_pkg::*;
#(
    parameter int                  INSTR_W   = DEF_INSTR_W,
    parameter int                  PC_W      = DEF_PC_W,
    parameter logic [PC_W-1:0]     PC_INC    = PC_W'(DEF_PC_INC),
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
    parameter int                  CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc_next,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    // same layout as if_id_t, sized by this instance's parameters
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_next;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t in_entry;
    logic   accept;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign in_entry = '{instr: in_instr, pc_next: in_pc + PC_INC};

    // next-state: flush wins; a free output prefers the skid entry over new input
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            main_d       = '{instr: NOP_INSTR, pc_next: '0};
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                main_d      = in_entry;
            end else begin
                out_valid_d  = 1'b0;
                main_d.instr = NOP_INSTR;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = in_entry;
        end
    end

    // main and skid entries with their valid bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q       <= '{instr: NOP_INSTR, pc_next: '0};
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = main_q.instr;
    assign out_pc_next = main_q.pc_next;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid_q & ~out_ready & ~flush),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & (out_valid_q | skid_valid_q)),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: vector table, corner sequences and FIFO-model random run for if_id_skid_reg
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, flush;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc_next;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_instr, s_out_pc_next;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_id_skid_reg dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc_next(out_pc_next), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_skid_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_instr(s_out_instr), .out_pc_next(s_out_pc_next), .flush(flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // reference model: in-order queue of held instructions (front = output)
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcn;
    } ent_t;
    ent_t        q[$];
    logic [31:0] pc_hold;
    int          m_stall, m_flush;

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        q.delete();
        pc_hold = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_step();
        int sz;
        bit acc;
        sz = q.size();
        if (flush) begin
            if (sz > 0) m_flush++;
            q.delete();
            pc_hold = 0;
        end else begin
            if (sz > 0 && !out_ready) m_stall++;
            acc = in_valid && sz < 2;
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back('{in_instr, in_pc + 32'd4});
            if (q.size() > 0) pc_hold = q[0].pcn;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply(logic v, logic [31:0] i, logic [31:0] p, logic r, logic f);
        in_valid  = v;
        in_instr  = i;
        in_pc     = p;
        out_ready = r;
        flush     = f;
        step();
    endtask

    task automatic check_model();
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("m_out_instr", out_instr, q.size() > 0 ? q[0].instr : 32'h0);
        chk("m_out_pc_next", out_pc_next, q.size() > 0 ? q[0].pcn : pc_hold);
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("m_stall_cnt", {16'd0, stall_cnt}, sat(m_stall, 65535));
        chk("m_flush_cnt", {16'd0, flush_cnt}, sat(m_flush, 65535));
        chk("m_sat_out_valid", {31'd0, s_out_valid}, {31'd0, q.size() > 0});
        chk("m_sat_stall_cnt", {28'd0, s_stall_cnt}, sat(m_stall, 15));
        chk("m_sat_flush_cnt", {28'd0, s_flush_cnt}, sat(m_flush, 15));
    endtask

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rdy;
        logic        fl;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        eir;
        int          es;
        int          ef;
    } vec_t;
    vec_t tv[19];

    initial begin
        tv[0]  = '{1'b1, 32'h2008_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h2008_0001, 32'h0000_0004, 1'b1, 0, 0};
        tv[1]  = '{1'b1, 32'h2009_0002, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'h2009_0002, 32'h0000_0008, 1'b1, 0, 0};
        tv[2]  = '{1'b1, 32'h200A_0003, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 32'h200A_0003, 32'h0000_000C, 1'b1, 0, 0};
        tv[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C, 1'b1, 0, 0};
        tv[4]  = '{1'b1, 32'h1111_1111, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_0104, 1'b1, 0, 0};
        tv[5]  = '{1'b1, 32'h2222_2222, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_0104, 1'b0, 1, 0};
        tv[6]  = '{1'b1, 32'h3333_3333, 32'h0000_0108, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_0104, 1'b0, 2, 0};
        tv[7]  = '{1'b1, 32'h3333_3333, 32'h0000_0108, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_0104, 1'b0, 3, 0};
        tv[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 32'h0000_0108, 1'b1, 3, 0};
        tv[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0108, 1'b1, 3, 0};
        tv[10] = '{1'b1, 32'h4444_4444, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h4444_4444, 32'h0000_0204, 1'b1, 3, 0};
        tv[11] = '{1'b1, 32'h5555_5555, 32'h0000_0204, 1'b0, 1'b0, 1'b1, 32'h4444_4444, 32'h0000_0204, 1'b0, 4, 0};
        tv[12] = '{1'b1, 32'h6666_6666, 32'h0000_0208, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 4, 1};
        tv[13] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 4, 1};
        tv[14] = '{1'b1, 32'h7777_7777, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h7777_7777, 32'h0000_0000, 1'b1, 4, 1};
        tv[15] = '{1'b1, 32'h8888_8888, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 32'h8888_8888, 32'h0000_0002, 1'b1, 4, 1};
        tv[16] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0002, 1'b1, 4, 1};
        tv[17] = '{1'b1, 32'h9999_9999, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 32'h9999_9999, 32'h0000_0304, 1'b1, 4, 1};
        tv[18] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 4, 2};

        reset = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1; flush = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc_next", out_pc_next, 32'h0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        reset = 1'b1;

        // directed vector table
        for (int k = 0; k < 19; k++) begin
            apply(tv[k].v, tv[k].instr, tv[k].pc, tv[k].rdy, tv[k].fl);
            chk($sformatf("vec%0d_out_valid", k), {31'd0, out_valid}, {31'd0, tv[k].ev});
            chk($sformatf("vec%0d_out_instr", k), out_instr, tv[k].ei);
            chk($sformatf("vec%0d_out_pc_next", k), out_pc_next, tv[k].ep);
            chk($sformatf("vec%0d_in_ready", k), {31'd0, in_ready}, {31'd0, tv[k].eir});
            chk($sformatf("vec%0d_stall_cnt", k), {16'd0, stall_cnt}, tv[k].es);
            chk($sformatf("vec%0d_flush_cnt", k), {16'd0, flush_cnt}, tv[k].ef);
        end

        // asynchronous reset between edges while the skid entry is full
        apply(1'b1, 32'hAAAA_0001, 32'h0000_0400, 1'b0, 1'b0);
        apply(1'b1, 32'hAAAA_0002, 32'h0000_0404, 1'b0, 1'b0);
        chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_instr", out_instr, 32'h0);
        chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("arst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // 20 stall cycles: 16-bit counter reaches 20, 4-bit counter sticks at 15
        apply(1'b1, 32'hBBBB_0001, 32'h0000_0500, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sat_stall_cnt16", {16'd0, stall_cnt}, 32'd20);
        chk("sat_stall_cnt4", {28'd0, s_stall_cnt}, 32'd15);
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_model();

        // randomized run against the queue model
        for (int k = 0; k < 600; k++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
            apply($urandom_range(0, 3) != 0, $urandom, pc,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
Parametrised IF/ID pipeline register for the 32-bit pipelined MIPS core. It adds to the basic IF/ID latch:
- a valid/ready handshake on both sides;
- a 2-entry skid buffer (main + skid), so the stall path from ID is registered;
- a synchronous flush for branches and jumps;
- the next-PC computation (PC + PC_INC) carried with each instruction;
- saturating stall and flush performance counters.

It sits between instruction fetch and decode.

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 32, program-counter width in bits
PC_INC, 4, constant added to the incoming PC to form the next-PC field
NOP_INSTR, 32'h0000_0000, value driven on out_instr whenever the stage holds a bubble
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset; 0 = reset
in_valid  in  1  IF presents an instruction
in_ready  out  1  stage can accept; equals ~skid_valid (registered, no combinational path from out_ready)
in_instr  in  INSTR_W  fetched instruction
in_pc  in  PC_W  PC of the fetched instruction
out_valid  out  1  ID-side instruction valid
out_ready  in  1  ID accepts the output (0 = stall)
out_instr  out  INSTR_W  instruction to decode
out_pc_next  out  PC_W  in_pc + PC_INC, modulo 2^PC_W
flush  in  1  synchronous kill of all held and incoming instructions
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones
flush_cnt  out  CNT_W  flush cycles that killed at least one valid entry; saturates

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, skid_valid=0 (so in_ready=1);
  - out_instr=NOP_INSTR, out_pc_next=0, skid data=0;
  - stall_cnt=0, flush_cnt=0.
- Accept: accept = in_valid & in_ready. The next-PC field (in_pc+PC_INC, carry discarded) is computed at accept and stored with the instruction.
- Drain: drain = out_valid & out_ready.
- Priority per cycle: flush > normal update.
- flush=1:
  - out_valid<=0, skid_valid<=0, out_instr<=NOP_INSTR, out_pc_next<=0;
  - any input accepted this cycle is discarded;
  - in_ready is 1 on the next cycle;
  - flush_cnt increments if out_valid|skid_valid was 1 before the edge.
- Normal update (flush=0):
  - Output free (out_valid=0 or drain):
    - if skid_valid: output loads the skid entry and skid_valid<=0 (an accept in this cycle cannot happen, since in_ready=0);
    - else if accept: output loads the input;
    - else: out_valid<=0 and out_instr<=NOP_INSTR, with out_pc_next held.
  - Output blocked (out_valid=1, out_ready=0): an accept loads the skid entry and sets skid_valid<=1. The output is unchanged.
- Ordering: instructions leave in acceptance order; none is lost or duplicated without a flush.
- Latency: 1 cycle from accept to out_valid with an empty stage. Throughput is 1 per cycle while out_ready=1.
- Counters:
  - stall_cnt increments when out_valid & ~out_ready & ~flush;
  - both counters hold at 2^CNT_W-1.
- Boundary cases:
  - out_ready toggling every cycle: no bubbles are inserted beyond back-pressure.
  - Simultaneous flush and drain: the drained instruction is consumed by ID this cycle (ID sees it valid); the stage empties after the edge.
  - Reset asserted mid-stall: everything clears immediately, without waiting for a clock edge.
  - in_pc = all-ones-minus-1: out_pc_next wraps to PC_INC-2 (e.g. 32'hFFFF_FFFE -> 32'h0000_0002).

Decomposition:
- Shared package (mips_pkg):
  - INSTR_W/PC_W defaults;
  - NOP_INSTR encoding (sll $0,$0,0);
  - PC_INC;
  - a packed if_id_t struct {instr, pc_next} used for both the main and skid entries.
- One natural sub-module, sat_counter (CNT_W-wide, inc enable, saturating, async active-low reset). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Reset then stream: reset low 3 cycles, release; in_valid=1 with in_pc=0x0,0x4,0x8 and instr 0x20080001,0x20090002,0x200A0003, out_ready=1 -> outputs appear 1 cycle later in order with pc_next 0x4,0x8,0xC; in_ready stays 1; stall_cnt=0.
- Back-pressure/skid: out_ready=0 for 3 cycles while in_valid=1 -> first instr held on output, second captured in skid, in_ready=0 from the next cycle; stall_cnt=3; release -> both drain in order with no loss.
- Flush with full stage: main+skid valid, flush=1 with in_valid=1 -> next cycle out_valid=0, out_instr=0x00000000, in_ready=1, flush_cnt=1; the input from the flush cycle never appears.
- Flush when empty: flush=1 with out_valid=0, skid_valid=0 -> flush_cnt stays 0.
- Asynchronous reset mid-stall: assert reset between edges with skid full -> out_valid, in_ready=1 and counters are cleared before the next posedge.
- Wrap/saturation: in_pc=0xFFFFFFFC -> out_pc_next=0x00000000; CNT_W=4 with 20 stall cycles -> stall_cnt=15.
